// File: rtl/obi_interconnect_master_arb_if.sv
// Bus bundle for one slave-side arbiter of the OBI interconnect.
// The slave modport is the arbiter's view; the master modport is the
// environment's view (masters, address map and slave port).
interface obi_interconnect_master_arb_if #(
  parameter int MASTERS     = 3,
  parameter int MASTER_BITS = (MASTERS == 1) ? 1 : $clog2(MASTERS),
  parameter int OUTSTANDING = 2
);
  localparam int CNT_W = $clog2(OUTSTANDING + 1);

  logic [MASTERS-1:0]         master_req_i;
  logic [MASTERS-1:0][31:0]   master_addr_i;
  logic [31:0]                slave_addr_mask_i;
  logic [31:0]                slave_addr_base_i;
  logic                       slave_gnt_i;
  logic                       slave_rvalid_i;
  logic [MASTER_BITS-1:0]     master_sel_int_o;
  logic [MASTERS-1:0]         master_sel_vec_o;
  logic                       granted_master_o;
  logic [MASTER_BITS-1:0]     rsp_sel_int_o;
  logic [MASTERS-1:0]         rsp_sel_vec_o;
  logic                       rsp_valid_o;
  logic [CNT_W-1:0]           outstanding_o;

  modport slave (
    input  master_req_i, master_addr_i, slave_addr_mask_i, slave_addr_base_i,
           slave_gnt_i, slave_rvalid_i,
    output master_sel_int_o, master_sel_vec_o, granted_master_o,
           rsp_sel_int_o, rsp_sel_vec_o, rsp_valid_o, outstanding_o
  );

  modport master (
    output master_req_i, master_addr_i, slave_addr_mask_i, slave_addr_base_i,
           slave_gnt_i, slave_rvalid_i,
    input  master_sel_int_o, master_sel_vec_o, granted_master_o,
           rsp_sel_int_o, rsp_sel_vec_o, rsp_valid_o, outstanding_o
  );
endinterface

// File: rtl/obi_interconnect_master_arb.sv
// Per-slave OBI arbiter: address decode, fixed-priority / round-robin
// selection with grant lock while stalled, and an ID FIFO that steers
// rvalid back to the issuing master in order.
// Optional: define OBI_ARB_PROTOCOL_CHECK_EN to add the sticky proto_err_o.

// Per-master decode: request targets this slave.
module obi_arb_decode (
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] mask_i,
  input  logic [31:0] base_i,
  output logic        elig_o
);
  assign elig_o = req_i & ((addr_i & mask_i) == base_i);
endmodule

module obi_interconnect_master_arb #(
  parameter int MASTERS     = 3,
  parameter int MASTER_BITS = (MASTERS == 1) ? 1 : $clog2(MASTERS),
  parameter int ARB_MODE    = 0,
  parameter int OUTSTANDING = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  obi_interconnect_master_arb_if.slave bus
`ifdef OBI_ARB_PROTOCOL_CHECK_EN
  ,
  output logic proto_err_o
`endif
);
  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam int PTR_W = (OUTSTANDING == 1) ? 1 : $clog2(OUTSTANDING);

  logic [MASTERS-1:0]     eligible;
  logic [MASTER_BITS-1:0] cand, rr_idx, rr_ptr_q, lock_idx_q;
  logic                   cand_vld, lock_q, granted, handshake;
  logic                   full, empty, push, pop;

  logic [OUTSTANDING-1:0][MASTER_BITS-1:0] id_mem_q;
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       count_q;

  for (genvar m = 0; m < MASTERS; m++) begin : gen_dec
    obi_arb_decode u_dec (
      .req_i  (bus.master_req_i[m]),
      .addr_i (bus.master_addr_i[m]),
      .mask_i (bus.slave_addr_mask_i),
      .base_i (bus.slave_addr_base_i),
      .elig_o (eligible[m])
    );
  end

  // Candidate: locked master if still eligible, else priority / rr search.
  // Loops run high-to-low so the lowest index (or offset) wins.
  always_comb begin
    cand     = '0;
    cand_vld = 1'b0;
    rr_idx   = '0;
    if (lock_q && eligible[lock_idx_q]) begin
      cand     = lock_idx_q;
      cand_vld = 1'b1;
    end else if (ARB_MODE == 0) begin
      for (int i = MASTERS - 1; i >= 0; i--) begin
        if (eligible[i]) begin
          cand     = MASTER_BITS'(i);
          cand_vld = 1'b1;
        end
      end
    end else begin
      for (int i = MASTERS - 1; i >= 0; i--) begin
        rr_idx = MASTER_BITS'((int'(rr_ptr_q) + i) % MASTERS);
        if (eligible[rr_idx]) begin
          cand     = rr_idx;
          cand_vld = 1'b1;
        end
      end
    end
  end

  assign full      = (count_q == CNT_W'(OUTSTANDING));
  assign empty     = (count_q == '0);
  // Full is the registered occupancy: a same-cycle pop does not reopen the
  // grant. Nothing is granted while reset is held.
  assign granted   = cand_vld & ~full & rst_ni;
  assign handshake = granted & bus.slave_gnt_i;
  assign push      = handshake;
  assign pop       = bus.slave_rvalid_i & ~empty;

  assign bus.granted_master_o = granted;
  assign bus.master_sel_int_o = granted ? cand : '0;
  assign bus.rsp_valid_o      = pop;
  assign bus.rsp_sel_int_o    = empty ? '0 : id_mem_q[rd_ptr_q];
  assign bus.outstanding_o    = count_q;

  // One-hot views of the request and response selections.
  always_comb begin
    bus.master_sel_vec_o = '0;
    bus.rsp_sel_vec_o    = '0;
    if (granted) bus.master_sel_vec_o[cand] = 1'b1;
    if (pop)     bus.rsp_sel_vec_o[id_mem_q[rd_ptr_q]] = 1'b1;
  end

  // Round-robin pointer moves past the winner on every handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (MASTERS == 1) begin
      rr_ptr_q <= '0;
    end else if (handshake) begin
      rr_ptr_q <= (cand == MASTER_BITS'(MASTERS - 1)) ? '0 : cand + MASTER_BITS'(1);
    end
  end

  // Grant lock: hold a stalled selection; drop it after the handshake or
  // when the locked master abandons the request. Kept while full.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (handshake) begin
      lock_q     <= 1'b0;
    end else if (granted) begin
      lock_q     <= 1'b1;
      lock_idx_q <= cand;
    end else if (lock_q && !eligible[lock_idx_q]) begin
      lock_q     <= 1'b0;
    end
  end

  // ID FIFO of accepted transactions awaiting rvalid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_mem_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        id_mem_q[wr_ptr_q] <= cand;
        wr_ptr_q <= (wr_ptr_q == PTR_W'(OUTSTANDING - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(OUTSTANDING - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef OBI_ARB_PROTOCOL_CHECK_EN
  // Sticky flag: rvalid with nothing outstanding, or locked master dropping req.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      proto_err_o <= 1'b0;
    end else if ((bus.slave_rvalid_i && empty) ||
                 (lock_q && !bus.master_req_i[lock_idx_q])) begin
      proto_err_o <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/obi_interconnect_master_arb.md
Name: obi_interconnect_master_arb

Overview:
- Per-slave arbiter for the OBI system-bus interconnect; one instance sits in front of each slave port.
- Selects one of MASTERS requesters whose address decodes to this slave, using fixed-priority or round-robin arbitration.
- Holds the selection stable while a request is stalled by the slave (grant lock).
- Tracks accepted-but-unanswered transactions in an ID FIFO so read responses (rvalid) are steered back to the issuing master in order.

Parameters:
- MASTERS, 3, number of requesting masters (>=1).
- MASTER_BITS, (MASTERS==1 ? 1 : $clog2(MASTERS)), width of the master index.
- ARB_MODE, 0, 0 = fixed priority (index 0 highest); 1 = round-robin.
- OUTSTANDING, 2, max accepted transactions awaiting rvalid (>=1); depth of the ID FIFO.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- master_req_i  in  1 x [MASTERS]  OBI req per master
- master_addr_i  in  32 x [MASTERS]  OBI addr per master
- slave_addr_mask_i  in  32  slave decode mask
- slave_addr_base_i  in  32  slave decode base
- slave_gnt_i  in  1  OBI gnt from slave
- slave_rvalid_i  in  1  OBI rvalid from slave
- master_sel_int_o  out  MASTER_BITS  index of the granted master (request channel)
- master_sel_vec_o  out  MASTERS  one-hot granted master
- granted_master_o  out  1  a master is selected this cycle
- rsp_sel_int_o  out  MASTER_BITS  index of the master owning the oldest outstanding transaction
- rsp_sel_vec_o  out  MASTERS  one-hot of rsp_sel_int_o, qualified by rsp_valid_o
- rsp_valid_o  out  1  slave_rvalid_i AND FIFO not empty
- outstanding_o  out  $clog2(OUTSTANDING+1)  current FIFO occupancy

Behaviour:
- Decode: eligible[m] = master_req_i[m] & ((master_addr_i[m] & slave_addr_mask_i) == slave_addr_base_i).
- Selection is combinational, same cycle as req; zero-cycle grant path.
- ARB_MODE=0: lowest eligible index wins.
- ARB_MODE=1: search starts at rr_ptr and wraps MASTERS-1 -> 0; first eligible wins.
  - On each handshake (granted_master_o & slave_gnt_i) with winner k: rr_ptr <= (k==MASTERS-1) ? 0 : k+1.
  - rr_ptr is unchanged when there is no handshake.
- Grant lock:
  - Condition: a master k is selected and slave_gnt_i=0.
  - Next cycle: lock_q=1 and lock_idx_q=k; while locked, selection is forced to lock_idx_q regardless of higher-priority requests or the rr pointer.
  - Lock clears on the cycle after the handshake.
  - Lock also clears if the locked master deasserts req or stops decoding to this slave (protocol violation); the arbiter then re-arbitrates that cycle.
- ID FIFO:
  - Push winner index on handshake; pop on slave_rvalid_i when not empty.
  - rsp_sel_* reflects the FIFO head.
  - Push and pop in the same cycle: occupancy unchanged, head advances, new entry written.
- Full: when occupancy == OUTSTANDING, master_sel_vec_o = 0 and granted_master_o = 0, even if rvalid pops this cycle (registered-full decision, no bypass).
  - An existing lock is retained while full, so the stalled master regains selection once space frees.
- Empty: slave_rvalid_i is ignored; rsp_valid_o = 0, no pop, occupancy stays 0.
- MASTERS==1: rr_ptr is constant 0; all index outputs are 0.
- Reset (async, any time including mid-transaction): rr_ptr=0, lock_q=0, FIFO pointers and occupancy=0.
  - With no eligible requests: master_sel_int_o=0, master_sel_vec_o=0, granted_master_o=0, rsp_sel_int_o=0, rsp_sel_vec_o=0, rsp_valid_o=0, outstanding_o=0.
  - In-flight transactions are discarded; no response steering after reset.

Optional Feature:
- Macro: OBI_ARB_PROTOCOL_CHECK_EN.
- Defined: adds output port proto_err_o (1 bit, reset 0). It is sticky until reset and sets the cycle after either event:
  - slave_rvalid_i while the FIFO is empty;
  - the locked master dropping req before gnt.
- Undefined: port absent; both events handled silently as above.

Test Plan:
- ARB_MODE=0, MASTERS=3, masters 1 and 2 request same slave, gnt=1 -> master_sel_int_o=1, vec=3'b010; master 2 granted only after master 1 drops req.
- ARB_MODE=1, masters 0,1,2 request continuously, gnt=1 every cycle -> grant order 0,1,2,0,1,2; rr_ptr wraps to 0 after index 2.
- Master 2 requests, gnt=0 for 3 cycles, master 0 requests on cycle 1 -> selection stays 2 until the gnt cycle; master 0 selected the following cycle.
- OUTSTANDING=2: two handshakes with no rvalid -> outstanding_o=2, granted_master_o=0 with a pending req; one rvalid -> rsp_sel_int_o = first master; grant resumes next cycle.
- Handshake by master 1 and rvalid for master 0 in the same cycle at occupancy 1 -> occupancy stays 1; head becomes master 1.
- Reset asserted with occupancy 2 and lock active -> all outputs 0 immediately; post-reset rvalid gives rsp_valid_o=0 (proto_err_o=1 next cycle when OBI_ARB_PROTOCOL_CHECK_EN is defined).
